// File: rtl/boreal_apex_core_mc_if.sv
// ---------------------------------------------------------------------------
// boreal_apex_core_mc_if
//   Bundles the tagged sample stream, the weight-memory read port and the
//   tagged result stream of boreal_apex_core_mc.
//
//   Signals
//     in_valid / in_ready   sample handshake
//     in_ch, in_data        channel tag and signed raw sample
//     w_addr, w_data        weight read port (w_data valid 1 cycle after w_addr)
//     out_valid             one-cycle result strobe
//     out_ch, mu_out,
//     eps_out, reward       tagged result, held between strobes
//     err_ch                one-cycle pulse for an out-of-range channel tag
//
//   Modports
//     slave   the core
//     master  the environment (sample source, weight memory, result sink)
// ---------------------------------------------------------------------------
interface boreal_apex_core_mc_if #(
    parameter int CW = 2,
    parameter int DW = 24,
    parameter int MW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CW-1:0]        in_ch;
    logic signed [DW-1:0] in_data;
    logic [CW-1:0]        w_addr;
    logic signed [MW-1:0] w_data;
    logic                 out_valid;
    logic [CW-1:0]        out_ch;
    logic signed [MW-1:0] mu_out;
    logic signed [MW-1:0] eps_out;
    logic                 reward;
    logic                 err_ch;

    modport slave (
        input  in_valid, in_ch, in_data, w_data,
        output in_ready, w_addr, out_valid, out_ch, mu_out, eps_out, reward, err_ch
    );

    modport master (
        output in_valid, in_ch, in_data, w_data,
        input  in_ready, w_addr, out_valid, out_ch, mu_out, eps_out, reward, err_ch
    );
endinterface

// File: rtl/boreal_apex_core_mc.sv
// ---------------------------------------------------------------------------
// boreal_apex_core_mc
//   Time-multiplexes NCH EEG channels through one datapath: IIR DC-block,
//   free-energy gradient step on a per-channel latent mu and an optional
//   lag-lead correction of the reported latent. One sample in flight;
//   accept-to-strobe latency is 4 cycles, throughput 1 sample per 5 cycles.
//
//   Ports
//     clk       system clock
//     rst       synchronous, active-high reset (priority over freeze_n)
//     freeze_n  active-low interlock: clears all channel state, aborts work
//     bus       boreal_apex_core_mc_if.slave (sample in, weight port, result out)
//
//   Optional feature
//     BOREAL_LEAD_COMP_EN  when defined, mu_out = sat(mu_new + LEAD_K*(mu_new-mu)>>>8)
//                          and the mu_prev history array is kept; otherwise
//                          mu_out = mu_new.
// ---------------------------------------------------------------------------
module boreal_apex_core_mc #(
    parameter int          NCH       = 4,
    parameter int          DW        = 24,
    parameter int          MW        = 16,
    parameter logic [15:0] ALPHA     = 16'hFEB8,  // unsigned Q0.16
    parameter logic [15:0] ETA       = 16'h0080,  // Q1.15
    parameter logic [15:0] LAMBDA    = 16'h0008,  // Q1.15
`ifdef BOREAL_LEAD_COMP_EN
    parameter logic [15:0] LEAD_K    = 16'h0020,  // Q8.8
`endif
    parameter int          REWARD_TH = 100
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 freeze_n,
    boreal_apex_core_mc_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic signed [63:0] MW_MAX = (64'sd1 <<< (MW - 1)) - 64'sd1;
    localparam logic signed [63:0] MW_MIN = -(64'sd1 <<< (MW - 1));
    localparam logic signed [63:0] DW_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam logic signed [63:0] DW_MIN = -(64'sd1 <<< (DW - 1));

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FILT, S_GRAD, S_UPD} state_t;

    function automatic logic signed [MW-1:0] sat_mw(input logic signed [63:0] v);
        logic signed [63:0] c;
        c = v;
        if (v > MW_MAX)      c = MW_MAX;
        else if (v < MW_MIN) c = MW_MIN;
        return MW'(c);
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [63:0] v);
        logic signed [63:0] c;
        c = v;
        if (v > DW_MAX)      c = DW_MAX;
        else if (v < DW_MIN) c = DW_MIN;
        return DW'(c);
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        ch_q;
    logic signed [DW-1:0] x_q, xp_q, yp_q, y_q;
    logic signed [MW-1:0] mu_q, eps_q;
    logic signed [MW+1:0] d_q;

    logic signed [DW-1:0] x_prev [NCH];
    logic signed [DW-1:0] y_prev [NCH];
    logic signed [MW-1:0] mu_arr [NCH];
`ifdef BOREAL_LEAD_COMP_EN
    logic signed [MW-1:0] mu_prev [NCH];
`endif

    logic                 accept, bad_ch;
    logic signed [DW-1:0] y_sat;
    logic signed [MW-1:0] eps_sat, mu_new, mu_lead;
    logic signed [MW+1:0] d_next;
    logic                 reward_next;

    assign accept = bus.in_valid & bus.in_ready;
    // Widen by one bit so NCH itself is representable when NCH is a power of two.
    assign bad_ch = ({1'b0, bus.in_ch} >= (CW + 1)'(NCH));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst)            state_q <= S_IDLE;
        else if (!freeze_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and infers a latch.
        state_d     = state_q;
        bus.in_ready = (state_q == S_IDLE) && freeze_n && !rst;
        bus.w_addr   = '0;
        unique case (state_q)
            S_IDLE:  if (accept && !bad_ch) state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_FILT;
                if (!rst) bus.w_addr = ch_q;
            end
            S_FILT:  state_d = S_GRAD;
            S_GRAD:  state_d = S_UPD;
            S_UPD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Arithmetic, evaluated at full 64-bit precision and saturated at the
    // architectural widths so nothing can wrap.
    always_comb begin : datapath
        logic signed [63:0] t, sp, g;
        t = 64'(x_q) - 64'(xp_q) + ((64'(yp_q) * $signed({48'd0, ALPHA})) >>> 16);
        y_sat = sat_dw(t);
        t = (64'(y_sat) >>> (DW - MW)) - ((64'(bus.w_data) * 64'(mu_q)) >>> (MW - 1));
        eps_sat = sat_mw(t);

        // Softplus-like slope: shrinks to zero as |mu| approaches full scale.
        sp = MW_MAX - ((mu_q < 0) ? -64'(mu_q) : 64'(mu_q));
        if (sp < 0) sp = '0;
        g = 64'(sat_mw((64'(eps_q) * sp) >>> (MW - 1)))
          - ((64'($signed(LAMBDA)) * 64'(mu_q)) >>> 15);
        t = (64'($signed(ETA)) * g) >>> 15;
        d_next = (MW + 2)'(t);

        mu_new = sat_mw(64'(mu_q) + 64'(d_q));
`ifdef BOREAL_LEAD_COMP_EN
        t = 64'(mu_new) - 64'(mu_q);
        mu_lead = sat_mw(64'(mu_new) + ((64'($signed(LEAD_K)) * t) >>> 8));
`else
        mu_lead = mu_new;
`endif
        reward_next = (((eps_q < 0) ? -64'(eps_q) : 64'(eps_q)) < 64'(REWARD_TH));
    end

    // Pipeline, channel state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the channel arrays are reset explicitly because their
            // cleared contents are observable (first sample after reset).
            for (int i = 0; i < NCH; i++) begin
                x_prev[i] <= '0;
                y_prev[i] <= '0;
                mu_arr[i] <= '0;
`ifdef BOREAL_LEAD_COMP_EN
                mu_prev[i] <= '0;
`endif
            end
            ch_q <= '0; x_q <= '0; xp_q <= '0; yp_q <= '0; y_q <= '0;
            mu_q <= '0; eps_q <= '0; d_q <= '0;
            bus.out_valid <= 1'b0; bus.out_ch <= '0; bus.mu_out <= '0;
            bus.eps_out <= '0; bus.reward <= 1'b0; bus.err_ch <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.err_ch    <= 1'b0;
            if (!freeze_n) begin
                for (int i = 0; i < NCH; i++) begin
                    x_prev[i] <= '0;
                    y_prev[i] <= '0;
                    mu_arr[i] <= '0;
`ifdef BOREAL_LEAD_COMP_EN
                    mu_prev[i] <= '0;
`endif
                end
            end else begin
                unique case (state_q)
                    S_IDLE: if (accept) begin
                        if (bad_ch) begin
                            bus.err_ch <= 1'b1;
                        end else begin
                            ch_q <= bus.in_ch;
                            x_q  <= bus.in_data;
                        end
                    end
                    S_FETCH: begin
                        xp_q <= x_prev[ch_q];
                        yp_q <= y_prev[ch_q];
                        mu_q <= mu_arr[ch_q];
                    end
                    S_FILT: begin
                        y_q   <= y_sat;
                        eps_q <= eps_sat;
                    end
                    S_GRAD: d_q <= d_next;
                    S_UPD: begin
                        x_prev[ch_q] <= x_q;
                        y_prev[ch_q] <= y_q;
                        mu_arr[ch_q] <= mu_new;
`ifdef BOREAL_LEAD_COMP_EN
                        mu_prev[ch_q] <= mu_q;
`endif
                        bus.out_valid <= 1'b1;
                        bus.out_ch    <= ch_q;
                        bus.mu_out    <= mu_lead;
                        bus.eps_out   <= eps_q;
                        bus.reward    <= reward_next;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boreal_apex_core_mc.sv
// ---------------------------------------------------------------------------
// tb_boreal_apex_core_mc
//   Directed and randomized checks of boreal_apex_core_mc against a plain
//   arithmetic model of the channel filter/gradient rules. NCH is 5 so that
//   3-bit tags above the channel count (e.g. 7) can be presented.
// ---------------------------------------------------------------------------
module tb_boreal_apex_core_mc;
    localparam int NCH = 5;
    localparam int CW  = 3;
    localparam int DW  = 24;
    localparam int MW  = 16;

    logic clk = 1'b0;
    logic rst;
    logic freeze_n;

    boreal_apex_core_mc_if #(.CW(CW), .DW(DW), .MW(MW)) bus ();

    boreal_apex_core_mc #(.NCH(NCH), .DW(DW), .MW(MW)) dut (
        .clk      (clk),
        .rst      (rst),
        .freeze_n (freeze_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Weight memory: registered read, data one cycle after address.
    logic signed [MW-1:0] wmem [8];
    always @(posedge clk) bus.w_data <= wmem[bus.w_addr];

    int errors = 0;
    int checks = 0;

    longint m_xp [8];
    longint m_yp [8];
    longint m_mu [8];

    logic signed [MW-1:0] last_eps, last_mu;
    logic                 last_rw;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Channel model: one sample through DC-block, error, gradient step.
    task automatic model(input int ch, input longint x, input longint w,
                         output longint e_eps, output longint e_mu, output logic e_rw);
        longint y, sp, g, d, mun;
        y     = sat(x - m_xp[ch] + ((65208 * m_yp[ch]) >>> 16), DW);
        e_eps = sat((y >>> 8) - ((w * m_mu[ch]) >>> 15), MW);
        sp    = 32767 - absl(m_mu[ch]);
        if (sp < 0) sp = 0;
        g     = sat((e_eps * sp) >>> 15, MW) - ((8 * m_mu[ch]) >>> 15);
        d     = (128 * g) >>> 15;
        mun   = sat(m_mu[ch] + d, MW);
`ifdef BOREAL_LEAD_COMP_EN
        e_mu  = sat(mun + ((32 * (mun - m_mu[ch])) >>> 8), MW);
`else
        e_mu  = mun;
`endif
        e_rw  = (absl(e_eps) < 100);
        m_xp[ch] = x;
        m_yp[ch] = y;
        m_mu[ch] = mun;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic signed [DW-1:0] d,
                        input logic signed [MW-1:0] w, input string tag);
        longint e_eps, e_mu;
        logic   e_rw;
        int     n;
        wmem[ch] = w;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, bus.in_ready, 1);
        model(ch, longint'(d), longint'(w), e_eps, e_mu, e_rw);
        bus.in_valid = 1'b1;
        bus.in_ch    = ch[CW-1:0];
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_out_ch"}, bus.out_ch, ch);
        check({tag, "_eps"}, bus.eps_out, e_eps);
        check({tag, "_mu"}, bus.mu_out, e_mu);
        check({tag, "_reward"}, bus.reward, e_rw);
        last_eps = bus.eps_out;
        last_mu  = bus.mu_out;
        last_rw  = bus.reward;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [MW-1:0] prev_mu, prev_eps;
        int hits;
        int r;
        logic signed [DW-1:0] d;

        for (int i = 0; i < 8; i++) begin
            wmem[i] = '0;
            m_xp[i] = 0;
            m_yp[i] = 0;
            m_mu[i] = 0;
        end
        rst          = 1'b1;
        freeze_n     = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;

        // Reset: three cycles, everything quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 0);
        end
        check("rst_mu_out", bus.mu_out, 0);
        check("rst_eps_out", bus.eps_out, 0);
        check("rst_err_ch", bus.err_ch, 0);
        check("rst_w_addr", bus.w_addr, 0);
        check("rst_reward", bus.reward, 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1);
        check("rel_out_valid", bus.out_valid, 0);

        // First sample on channel 0.
        send(0, 24'sd1000, 16'sd0, "t2");
        check("t2_eps_const", last_eps, 3);
        check("t2_reward_const", last_rw, 1);
        check("t2_mu_const", last_mu, 0);

        // Repeated full-scale-half step on channel 2.
        prev_mu  = 16'sd0;
        prev_eps = 16'sh7FFF;
        for (int i = 0; i < 6; i++) begin
            send(2, 24'sd4194304, 16'sd0, "t3");
            check("t3_mu_rises", (last_mu > prev_mu), 1);
            check("t3_eps_decays", (last_eps < prev_eps), 1);
            check("t3_mu_nonneg", (last_mu >= 0), 1);
            prev_mu  = last_mu;
            prev_eps = last_eps;
        end

        // Bad channel tag.
        bus.in_valid = 1'b1;
        bus.in_ch    = 3'd7;
        bus.in_data  = 24'sh7FFFFF;
        tick();
        bus.in_valid = 1'b0;
        check("t4_err_pulse", bus.err_ch, 1);
        check("t4_no_strobe0", bus.out_valid, 0);
        tick();
        check("t4_err_clear", bus.err_ch, 0);
        check("t4_ready_back", bus.in_ready, 1);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) hits++;
        end
        check("t4_no_strobe", hits, 0);
        send(3, 24'sd0, 16'sd0, "t4_ch3");
        send(2, 24'sd4194304, 16'sd0, "t4_ch2");

        // Freeze during GRAD drops the sample and clears every channel.
        bus.in_valid = 1'b1;
        bus.in_ch    = 3'd1;
        bus.in_data  = 24'sd5000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        freeze_n = 1'b0;
        #1;
        check("t5_ready_low_a", bus.in_ready, 0);
        hits = 0;
        tick();
        check("t5_ready_low_b", bus.in_ready, 0);
        if (bus.out_valid) hits++;
        tick();
        if (bus.out_valid) hits++;
        freeze_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) hits++;
        end
        check("t5_no_strobe", hits, 0);
        for (int i = 0; i < 8; i++) begin
            m_xp[i] = 0;
            m_yp[i] = 0;
            m_mu[i] = 0;
        end
        send(2, 24'sd4194304, 16'sd0, "t5");
        check("t5_eps_first", last_eps, 16384);
`ifdef BOREAL_LEAD_COMP_EN
        check("t6_mu_lead", last_mu, 70);
`else
        check("t6_mu_plain", last_mu, 63);
`endif

        // Reward threshold boundary on freshly cleared channels.
        send(0, 24'sd25600, 16'sd0, "rw100");
        check("rw100_eps", last_eps, 100);
        check("rw100_reward", last_rw, 0);
        send(1, 24'sd25344, 16'sd0, "rw99");
        check("rw99_eps", last_eps, 99);
        check("rw99_reward", last_rw, 1);

        // Randomized samples, including full-scale extremes and weights.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      d = 24'sh7FFFFF;
            else if (r == 1) d = 24'sh800000;
            else             d = DW'($urandom);
            send(int'($urandom_range(0, NCH - 1)), d, MW'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
